// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one iterative WIDTH x WIDTH multiplier among
// N_REQ requesters with round-robin arbitration. Each result is returned
// with the index of the requester that issued it.
//
// Handshakes:
//   requester side - req[i] is a level held with stable operands until
//   gnt[i] pulses for one cycle; that cycle is the accept. done_valid
//   pulses once per accepted job with done_id/done_r.
//   multiplier side - mult_start pulses for one cycle while mult_ready=1;
//   the multiplier drops mult_ready the next cycle and raises it again with
//   mult_r valid. Zero-operand jobs may leave mult_ready high throughout.
//
// Optional build macro: MULT_SHARE_ZERO_BYPASS_EN - jobs with a zero operand
// skip the multiplier and respond with 0 one cycle after the grant.
module mult_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         gnt,
    output logic                     done_valid,
    output logic [ID_W-1:0]          done_id,
    output logic [2*WIDTH-1:0]       done_r,
    output logic                     busy,
    output logic                     mult_start,
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    input  logic                     mult_ready,
    input  logic [2*WIDTH-1:0]       mult_r
);

    localparam logic [2:0] ARB       = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    logic [2:0]         state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] r_q;
    logic               wb_second;

    logic               found;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    ptr_next;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               grant_now;
    logic               bypass;

    // Round-robin search: first set request at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
    end

    // Operand select for the winner, grant decode and pointer advance.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win == ID_W'(k)) begin
                sel_a = req_a[k*WIDTH +: WIDTH];
                sel_b = req_b[k*WIDTH +: WIDTH];
            end
        end
        grant_now = !rst && (state == ARB) && found && mult_ready;
        gnt = '0;
        if (grant_now) begin
            gnt[win] = 1'b1;
        end
        ptr_next = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
        bypass = (sel_a == '0) || (sel_b == '0);
`else
        bypass = 1'b0;
`endif
    end

    // Job sequencer: grant, start pulse, wait for the multiplier, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            ptr       <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            wb_second <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (grant_now) begin
                        a_q  <= sel_a;
                        b_q  <= sel_b;
                        id_q <= win;
                        ptr  <= ptr_next;
                        if (bypass) begin
                            r_q   <= '0;
                            state <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wb_second <= 1'b0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!mult_ready) begin
                        state <= WAIT_DONE;
                    end else if (wb_second) begin
                        // Ready never dropped: one-cycle (zero operand) job.
                        r_q   <= mult_r;
                        state <= RESP;
                    end else begin
                        wb_second <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (mult_ready) begin
                        r_q   <= mult_r;
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= ARB;
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

    assign done_valid = (state == RESP);
    assign done_id    = id_q;
    assign done_r     = r_q;
    assign busy       = (state != ARB);
    assign mult_start = (state == ISSUE);
    assign mult_a     = a_q;
    assign mult_b     = b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter with an iterative multiplier model,
// a round-robin reference model and a result scoreboard.
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

`ifdef MULT_SHARE_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     gnt;
    logic             done_valid;
    logic [IDW-1:0]   done_id;
    logic [2*W-1:0]   done_r;
    logic             busy;
    logic             mult_start;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_b;
    logic             mult_ready;
    logic [2*W-1:0]   mult_r;

    mult_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done_valid(done_valid), .done_id(done_id), .done_r(done_r),
        .busy(busy), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_ready(mult_ready), .mult_r(mult_r)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic rst_d;
    always @(posedge clk) rst_d <= rst;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // iterative multiplier model
    int         lat_min = 1;
    int         lat_max = 6;
    int         m_cnt;
    logic [7:0] m_pa, m_pb;
    always @(posedge clk) begin
        if (rst) begin
            mult_ready <= 1'b1;
            mult_r     <= '0;
            m_cnt      <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mult_ready <= 1'b1;
                mult_r     <= 16'(m_pa) * 16'(m_pb);
            end
        end else if (mult_start && mult_ready) begin
            if (mult_a == 0 || mult_b == 0) begin
                mult_r <= '0;
            end else begin
                mult_ready <= 1'b0;
                m_cnt      <= $urandom_range(lat_min, lat_max);
                m_pa       <= mult_a;
                m_pb       <= mult_b;
            end
        end
    end

    // reference model + scoreboard
    logic [IDW+15:0] exp_q[$];
    logic [IDW+15:0] done_log[$];
    int              ptr_m;
    bit              m_busy;
    int              lat;
    int              starts;
    logic [7:0]      cur_a, cur_b;
    bit              cur_zero;
    logic [15:0]     last_r;
    logic [N-1:0]    gnt_seen;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        int          w;
        logic [15:0] prod;
        logic [IDW+15:0] e;
        bit          exp_start;
        if (rst) begin
            ptr_m = 0; m_busy = 0; lat = 0; starts = 0; last_r = '0;
            exp_q.delete();
            gnt_seen = '0;
            if (rst_d) begin
                check("rst_gnt", gnt, 0);
                check("rst_done_valid", done_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_mult_start", mult_start, 0);
                check("rst_mult_a", mult_a, 0);
                check("rst_mult_b", mult_b, 0);
                check("rst_done_r", done_r, 0);
                check("rst_done_id", done_id, 0);
            end
        end else begin
            gnt_seen = gnt;
            if (m_busy) lat++;
            check("busy", busy, m_busy);
            exp_start = m_busy && lat == 1 && !(BYPASS && cur_zero);
            check("mult_start", mult_start, exp_start);
            if (mult_start) begin
                check("mult_a", mult_a, cur_a);
                check("mult_b", mult_b, cur_b);
                starts++;
            end
            if (!m_busy && req != 0 && mult_ready) begin
                w = pick(req, ptr_m);
                check("gnt", gnt, 32'(1) << w);
                cur_a    = req_a[w*W +: W];
                cur_b    = req_b[w*W +: W];
                cur_zero = (cur_a == 0) || (cur_b == 0);
                prod     = 16'(cur_a) * 16'(cur_b);
                exp_q.push_back({w[IDW-1:0], prod});
                ptr_m  = (w + 1) % N;
                m_busy = 1;
                lat    = 0;
                starts = 0;
            end else begin
                check("gnt_idle", gnt, 0);
            end
            if (done_valid) begin
                done_log.push_back({done_id, done_r});
                if (!m_busy || exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_id", done_id, e[IDW+15:16]);
                    check("done_r", done_r, e[15:0]);
                    if (BYPASS && cur_zero) check("latency_bypass", lat, 1);
                    else check("latency_min4", lat >= 4, 1);
                    check("start_count", starts, (BYPASS && cur_zero) ? 0 : 1);
                    check("mult_a_hold", mult_a, cur_a);
                    check("mult_b_hold", mult_b, cur_b);
                    last_r = e[15:0];
                    m_busy = 0;
                end
            end else begin
                check("done_r_hold", done_r, last_r);
            end
        end
    end

    // driver tasks
    int mode;    // 0: drop after grant, 1: hold for budget, 2: random traffic
    int budget;

    function automatic logic [7:0] rand_op();
        int s;
        s = $urandom_range(0, 7);
        if (s == 0) return 8'd0;
        if (s == 1) return 8'd255;
        return 8'($urandom_range(1, 255));
    endfunction

    task automatic post(input int i, input logic [7:0] a, input logic [7:0] b);
        req[i] = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_seen[i]) begin
                if (mode == 1 && budget > 0) begin
                    budget--;
                end else if (mode == 2 && budget > 0 && $urandom_range(0, 2) == 0) begin
                    budget--;
                    post(i, rand_op(), rand_op());
                end else begin
                    req[i] = 1'b0;
                end
            end else if (mode == 2) begin
                if (!req[i] && budget > 0 && $urandom_range(0, 3) == 0) begin
                    budget--;
                    post(i, rand_op(), rand_op());
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int c;
        c = 0;
        step();
        while (!(req == 0 && budget == 0 && !m_busy && !busy) && c < max_cycles) begin
            step();
            c++;
        end
        if (c >= max_cycles) check("timeout_idle", 1, 0);
        step();
    endtask

    task automatic check_log(input string name, input int n,
                             input int id0, input int r0, input int id1, input int r1);
        check({name, "_count"}, done_log.size(), n);
        if (done_log.size() > 0 && n > 0) begin
            check({name, "_id0"}, done_log[0][IDW+15:16], id0);
            check({name, "_r0"}, done_log[0][15:0], r0);
        end
        if (done_log.size() > 1 && n > 1) begin
            check({name, "_id1"}, done_log[1][IDW+15:16], id1);
            check({name, "_r1"}, done_log[1][15:0], r1);
        end
    endtask

    // stimulus
    initial begin
        int rr_id[5];
        int rr_r[5];
        int c;
        rr_id = '{0, 1, 2, 3, 0};
        rr_r  = '{10, 20, 30, 40, 10};
        rst = 1'b1; req = '0; req_a = '0; req_b = '0;
        mode = 0; budget = 0;
        repeat (3) step();
        rst = 1'b0;

        // idle: nothing may happen for 20 cycles
        repeat (20) step();
        check("idle_no_done", done_log.size(), 0);

        // round robin with all requests held
        done_log.delete();
        mode = 1; budget = 1;
        for (int i = 0; i < N; i++) post(i, 8'(i + 1), 8'd10);
        wait_idle(200);
        check("rr_count", done_log.size(), 5);
        for (int k = 0; k < 5 && k < done_log.size(); k++) begin
            check("rr_id", done_log[k][IDW+15:16], rr_id[k]);
            check("rr_r", done_log[k][15:0], rr_r[k]);
        end
        mode = 0; budget = 0;

        // single job
        done_log.delete();
        post(2, 8'd3, 8'd5);
        wait_idle(100);
        check_log("single", 1, 2, 15, 0, 0);

        // max operands
        done_log.delete();
        post(1, 8'd255, 8'd255);
        wait_idle(100);
        check_log("max", 1, 1, 65025, 0, 0);

        // zero operand
        done_log.delete();
        post(0, 8'd0, 8'd7);
        wait_idle(100);
        check_log("zero", 1, 0, 0, 0, 0);

        // random traffic
        done_log.delete();
        mode = 2; budget = 80;
        wait_idle(3000);
        mode = 0; budget = 0;

        // reset while waiting on the multiplier
        lat_min = 6; lat_max = 6;
        done_log.delete();
        post(2, 8'd9, 8'd9);
        c = 0;
        step();
        while (!(busy && !mult_ready) && c < 50) begin
            step();
            c++;
        end
        check("reach_wait_done", busy && !mult_ready, 1);
        step();
        rst = 1'b1; req = '0;
        step(); step();
        rst = 1'b0;
        repeat (10) step();
        check("rst_abandon", done_log.size(), 0);
        lat_min = 1; lat_max = 6;
        post(3, 8'd4, 8'd5);
        post(1, 8'd6, 8'd7);
        wait_idle(100);
        check_log("after_rst", 2, 1, 42, 3, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #300000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
